// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, oversampled, majority-voted) feeding a 4-entry FIFO
// with sticky frame-error and overrun flags.
module uart_rx_fifo #(
  parameter logic [23:0] BAUD_RATE  = 24'd4000000,
  parameter logic [27:0] CLOCK_FREQ = 28'd100000000,
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic       clk_int,
  input  logic       uart_reset,
  input  logic       rx_d_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err,
  output logic [2:0] fifo_count,
  output logic       busy
);

  localparam int unsigned DIV_RAW  = 32'(CLOCK_FREQ) / (32'(BAUD_RATE) * OVERSAMPLE);
  localparam int unsigned TICK_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW       = $clog2(OVERSAMPLE);
  localparam int unsigned S_LO     = OVERSAMPLE / 2 - 1;
  localparam int unsigned S_MID    = OVERSAMPLE / 2;
  localparam int unsigned S_HI     = OVERSAMPLE / 2 + 1;
  localparam int unsigned S_LAST   = OVERSAMPLE - 1;
  localparam int unsigned DEPTH    = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_prev_q;
  logic            rx_s, fall_c;
  logic [TW-1:0]   tick_q;
  logic            tick_c, restart_c;
  logic [SW-1:0]   samp_q, samp_d;
  logic            lo_c, mid_c, hi_c, last_c;
  logic            samp_a_q, samp_b_q, maj_c;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_c, ferr_set_c;

  logic [7:0]      mem_q [DEPTH];
  logic [1:0]      wr_q, rd_q, rd_d;
  logic [2:0]      cnt_d;
  logic [7:0]      head_d;
  logic            full_c, pop_c, wr_en_c, ovr_set_c;

  assign rx_s   = sync_q[1];
  assign fall_c = rx_prev_q & ~rx_s;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk_int or posedge uart_reset) begin
    if (uart_reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_d_in};
      rx_prev_q <= sync_q[1];
    end
  end

  assign tick_c = (tick_q == TW'(TICK_DIV - 1));

  // Oversample tick divider, realigned to the detected start edge
  always_ff @(posedge clk_int or posedge uart_reset) begin
    if (uart_reset)               tick_q <= '0;
    else if (restart_c || tick_c) tick_q <= '0;
    else                          tick_q <= tick_q + TW'(1);
  end

  assign lo_c   = (samp_q == SW'(S_LO));
  assign mid_c  = (samp_q == SW'(S_MID));
  assign hi_c   = (samp_q == SW'(S_HI));
  assign last_c = (samp_q == SW'(S_LAST));
  assign maj_c  = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);

  // Next-state logic: bit timing, start validation, shifting and stop decision
  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    restart_c  = 1'b0;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    if (state_q == IDLE) begin
      if (fall_c) begin
        state_d   = START;
        samp_d    = '0;
        restart_c = 1'b1;
      end
    end else if (tick_c) begin
      samp_d = last_c ? '0 : samp_q + SW'(1);
      case (state_q)
        START: begin
          if (hi_c && maj_c) begin
            state_d = IDLE;
          end else if (last_c) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (hi_c) shift_d = {maj_c, shift_q[7:1]};
          if (last_c) begin
            if (bit_q == 3'd7) state_d = STOP;
            else               bit_d   = bit_q + 3'd1;
          end
        end
        STOP: begin
          if (hi_c) begin
            state_d    = IDLE;
            push_c     = maj_c;
            ferr_set_c = ~maj_c;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Receiver state, sample history and shift register
  always_ff @(posedge clk_int or posedge uart_reset) begin
    if (uart_reset) begin
      state_q  <= IDLE;
      samp_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy    <= (state_d != IDLE);
      if (tick_c && lo_c)  samp_a_q <= rx_s;
      if (tick_c && mid_c) samp_b_q <= rx_s;
    end
  end

  assign full_c    = (fifo_count == 3'd4);
  assign pop_c     = rx_valid & rx_ready;
  assign wr_en_c   = push_c & (~full_c | pop_c);
  assign ovr_set_c = push_c & full_c & ~pop_c;

  // Next occupancy and next head byte; a byte written into the new head slot is bypassed
  always_comb begin
    rd_d  = rd_q + 2'(pop_c);
    cnt_d = fifo_count + 3'(wr_en_c) - 3'(pop_c);
    if (cnt_d == 3'd0)                 head_d = '0;
    else if (wr_en_c && (wr_q == rd_d)) head_d = shift_q;
    else                               head_d = mem_q[rd_d];
  end

  // FIFO storage, pointers, registered head/valid and sticky flags (set beats clear)
  always_ff @(posedge clk_int or posedge uart_reset) begin
    if (uart_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      fifo_count <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + 2'd1;
      end
      rd_q       <= rd_d;
      fifo_count <= cnt_d;
      rx_valid   <= (cnt_d != 3'd0);
      rx_data    <= head_d;
      frame_err  <= ferr_set_c | (frame_err & ~clr_err);
      overrun    <= ovr_set_c  | (overrun   & ~clr_err);
    end
  end

endmodule
